// File: rtl/sd_response_capture_if.sv
// Bundles the SD-side inputs, the arm pulse and the captured-response outputs
// of sd_response_capture so they travel as one port.
interface sd_response_capture_if;
  logic        sd_clk_in;
  logic        sd_miso_in;
  logic        arm;
  logic [15:0] response_signal;
  logic        resp_valid;
  logic        resp_timeout;
  logic        busy;

  // Controller side: drives the card lines and arm, observes the result.
  modport master (
    output sd_clk_in,
    output sd_miso_in,
    output arm,
    input  response_signal,
    input  resp_valid,
    input  resp_timeout,
    input  busy
  );

  // Capture block side.
  modport slave (
    input  sd_clk_in,
    input  sd_miso_in,
    input  arm,
    output response_signal,
    output resp_valid,
    output resp_timeout,
    output busy
  );
endinterface

// File: rtl/sd_response_capture.sv
// SPI-mode SD response capture. Synchronises the slow SD clock and MISO into
// CLOCK_50, detects SD clock rising edges, hunts for the start bit after an
// arm pulse and shifts in an R1-style response MSB-first. Reports either a
// valid response or a timeout when the card stays silent too long.
module sd_response_capture #(
  parameter int RESP_BITS     = 8,
  parameter int TIMEOUT_EDGES = 64
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  sd_response_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [4:0]  RESP_LEN  = 5'(RESP_BITS);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT_EDGES);
  localparam logic [15:0] RESP_MASK = 16'((32'h1 << RESP_BITS) - 32'h1);

  // Synchroniser / edge-detect stages. MISO gets the same depth as the clock
  // path so the sampled bit lines up with the registered strobe.
  logic clk_s1_q, clk_s2_q, clk_prev_q, strobe_q;
  logic miso_s1_q, miso_s2_q, bit_s_q;

  logic        strobe;
  logic        bit_s;

  state_t      state_q, state_d;
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] resp_q, resp_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  logic [15:0] edge_inc;
  logic [4:0]  bit_inc;
  logic [15:0] shreg_shifted;

  // Two-flop synchronisers plus one edge stage for clock and data.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_prev_q <= 1'b0;
      strobe_q   <= 1'b0;
      miso_s1_q  <= 1'b0;
      miso_s2_q  <= 1'b0;
      bit_s_q    <= 1'b0;
    end else begin
      clk_s1_q   <= bus.sd_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      strobe_q   <= clk_s2_q & ~clk_prev_q;
      miso_s1_q  <= bus.sd_miso_in;
      miso_s2_q  <= miso_s1_q;
      bit_s_q    <= miso_s2_q;
    end
  end

  assign strobe = strobe_q;
  assign bit_s  = bit_s_q;

  // Saturating increments so neither counter can wrap.
  assign edge_inc      = (edge_cnt_q == 16'hFFFF) ? edge_cnt_q : edge_cnt_q + 16'd1;
  assign bit_inc       = (bit_cnt_q == 5'h1F) ? bit_cnt_q : bit_cnt_q + 5'd1;
  assign shreg_shifted = {shreg_q[14:0], bit_s};

  // Capture FSM state and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= 16'd0;
      bit_cnt_q  <= 5'd0;
      shreg_q    <= 16'd0;
      resp_q     <= 16'hFFFF;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      resp_q     <= resp_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state logic: arm always restarts the hunt and beats a coincident
  // strobe; strobes only matter in HUNT and SHIFT.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    resp_d     = resp_q;
    valid_d    = valid_q;
    timeout_d  = timeout_q;

    if (bus.arm) begin
      // The previous response word stays visible until a new result lands.
      state_d    = ST_HUNT;
      edge_cnt_d = 16'd0;
      bit_cnt_d  = 5'd0;
      shreg_d    = 16'd0;
      valid_d    = 1'b0;
      timeout_d  = 1'b0;
    end else if (strobe) begin
      case (state_q)
        ST_HUNT: begin
          if (!bit_s) begin
            // Start bit is the response MSB and is always zero.
            shreg_d   = 16'd0;
            bit_cnt_d = 5'd1;
            if (RESP_LEN == 5'd1) begin
              resp_d  = 16'd0;
              valid_d = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            edge_cnt_d = edge_inc;
            if (edge_inc >= TO_LIMIT) begin
              timeout_d = 1'b1;
              resp_d    = 16'hFFFF;
              state_d   = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          shreg_d   = shreg_shifted;
          bit_cnt_d = bit_inc;
          if (bit_inc >= RESP_LEN) begin
            resp_d  = shreg_shifted & RESP_MASK;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE ignore SD clock edges.
        end
      endcase
    end
  end

  assign bus.response_signal = resp_q;
  assign bus.resp_valid      = valid_q;
  assign bus.resp_timeout    = timeout_q;
  assign bus.busy            = (state_q == ST_HUNT) || (state_q == ST_SHIFT);

endmodule

// File: tb/tb_sd_response_capture.sv
// Directed bench for sd_response_capture: drives a slow SD clock and MISO
// pattern, checks results against hand-computed response words.
module tb_sd_response_capture;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  sd_response_capture_if bus ();

  sd_response_capture #(
    .RESP_BITS     (8),
    .TIMEOUT_EDGES (64)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic pre_valid, pre_timeout, pre_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic arm_pulse();
    @(negedge CLOCK_50);
    bus.arm = 1'b1;
    @(negedge CLOCK_50);
    bus.arm = 1'b0;
  endtask

  // Set MISO, then raise the SD clock on a CLOCK_50 falling edge.
  task automatic sd_rise(input logic b);
    @(negedge CLOCK_50);
    bus.sd_miso_in = b;
    repeat (4) @(negedge CLOCK_50);
    bus.sd_clk_in = 1'b1;
  endtask

  task automatic sd_fall();
    repeat (10) @(negedge CLOCK_50);
    bus.sd_clk_in = 1'b0;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic send_bit(input logic b);
    sd_rise(b);
    sd_fall();
  endtask

  // Final bit: capture flags while the strobe is live, then one cycle later.
  task automatic send_last(input logic b);
    sd_rise(b);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    pre_valid   = bus.resp_valid;
    pre_timeout = bus.resp_timeout;
    pre_busy    = bus.busy;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic send_resp(input logic [7:0] v);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    send_last(v[0]);
  endtask

  initial begin
    bus.sd_clk_in  = 1'b0;
    bus.sd_miso_in = 1'b1;
    bus.arm        = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_resp",    32'(bus.response_signal), 32'hFFFF);
    check("reset_valid",   32'(bus.resp_valid),      32'd0);
    check("reset_timeout", 32'(bus.resp_timeout),    32'd0);
    check("reset_busy",    32'(bus.busy),            32'd0);

    // Strobes before any arm are ignored.
    send_bit(1'b0);
    send_bit(1'b0);
    check("idle_ignore_busy", 32'(bus.busy), 32'd0);

    // R1 idle: two high bits, then 0000_0001.
    arm_pulse();
    check("r1_busy_after_arm", 32'(bus.busy), 32'd1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_resp(8'h01);
    check("r1_valid_before", 32'(pre_valid),           32'd0);
    check("r1_busy_before",  32'(pre_busy),            32'd1);
    check("r1_resp",         32'(bus.response_signal), 32'h0001);
    check("r1_valid",        32'(bus.resp_valid),      32'd1);
    check("r1_timeout",      32'(bus.resp_timeout),    32'd0);
    check("r1_busy",         32'(bus.busy),            32'd0);
    sd_fall();
    send_bit(1'b0);
    send_bit(1'b1);
    check("done_hold_resp",  32'(bus.response_signal), 32'h0001);
    check("done_hold_valid", 32'(bus.resp_valid),      32'd1);

    // Late response: 40 high bits, then 0x00.
    arm_pulse();
    check("late_valid_cleared", 32'(bus.resp_valid), 32'd0);
    for (int i = 0; i < 40; i++) send_bit(1'b1);
    check("late_still_hunting", 32'(bus.busy), 32'd1);
    send_resp(8'h00);
    check("late_resp",    32'(bus.response_signal), 32'h0000);
    check("late_valid",   32'(bus.resp_valid),      32'd1);
    check("late_timeout", 32'(bus.resp_timeout),    32'd0);
    sd_fall();

    // Re-arm mid-shift: partial 0,0,0 must never be reported.
    arm_pulse();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    arm_pulse();
    check("rearm_valid",     32'(bus.resp_valid),      32'd0);
    check("rearm_resp_kept", 32'(bus.response_signal), 32'h0000);
    check("rearm_busy",      32'(bus.busy),            32'd1);
    send_bit(1'b1);
    send_resp(8'h05);
    check("rearm_valid_before", 32'(pre_valid),           32'd0);
    check("rearm_resp",         32'(bus.response_signal), 32'h0005);
    check("rearm_valid_after",  32'(bus.resp_valid),      32'd1);
    sd_fall();

    // Reset mid-shift.
    arm_pulse();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_mid_resp",    32'(bus.response_signal), 32'hFFFF);
    check("rst_mid_valid",   32'(bus.resp_valid),      32'd0);
    check("rst_mid_timeout", 32'(bus.resp_timeout),    32'd0);
    check("rst_mid_busy",    32'(bus.busy),            32'd0);
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    check("rst_after_busy",  32'(bus.busy),            32'd0);
    check("rst_after_valid", 32'(bus.resp_valid),      32'd0);
    check("rst_after_resp",  32'(bus.response_signal), 32'hFFFF);

    // Give the response word a non-timeout value first.
    arm_pulse();
    send_resp(8'h3C);
    check("pre_to_resp", 32'(bus.response_signal), 32'h003C);
    sd_fall();

    // No response: MISO high for 64 SD edges.
    arm_pulse();
    for (int i = 0; i < 63; i++) send_bit(1'b1);
    check("to_63_busy",    32'(bus.busy),         32'd1);
    check("to_63_timeout", 32'(bus.resp_timeout), 32'd0);
    send_last(1'b1);
    check("to_timeout_before", 32'(pre_timeout),         32'd0);
    check("to_timeout",        32'(bus.resp_timeout),    32'd1);
    check("to_resp",           32'(bus.response_signal), 32'hFFFF);
    check("to_valid",          32'(bus.resp_valid),      32'd0);
    check("to_busy",           32'(bus.busy),            32'd0);
    sd_fall();

    // Arm/strobe collision: the zero bit coinciding with arm is discarded.
    arm_pulse();
    send_bit(1'b1);
    check("coll_timeout_cleared", 32'(bus.resp_timeout), 32'd0);
    sd_rise(1'b0);
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    bus.arm = 1'b1;
    @(negedge CLOCK_50);
    bus.arm = 1'b0;
    sd_fall();
    for (int i = 7; i >= 1; i--) send_bit(i == 1);
    check("coll_not_done_early", 32'(bus.resp_valid), 32'd0);
    send_last(1'b1);
    check("coll_valid_before", 32'(pre_valid),           32'd0);
    check("coll_resp",         32'(bus.response_signal), 32'h0003);
    check("coll_valid",        32'(bus.resp_valid),      32'd1);
    sd_fall();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_response_capture.md
# sd_response_capture

Captures the SD card's serial response from the data-out line in SPI mode, clocked by the 250 kHz SD clock. It produces the parallel `response_signal` word that the SD controller checks to drop its gate. After a command has been sent, the block hunts for the start bit and shifts in an R1-style response MSB-first. It then presents the result with a valid flag, or a timeout flag if the card never answers.

## Interface
Parameters:
- `RESP_BITS`, default 8: response length in bits, including the leading 0 bit; legal range 1–16.
- `TIMEOUT_EDGES`, default 64: number of sampled high bits allowed in HUNT before timeout (Ncr max, 8 bytes); legal range 1–65535.

Ports:
- `CLOCK_50`, in, 1: 50 MHz system clock; all logic is in this domain.
- `reset`, in, 1: synchronous, active-high reset.
- `sd_clk_in`, in, 1: 250 kHz SD clock, asynchronous to `CLOCK_50`.
- `sd_miso_in`, in, 1: card data-out line, asynchronous; idles high.
- `arm`, in, 1: single-cycle pulse marking the end of the command; starts a capture.
- `response_signal`, out, 16: captured response, right-aligned, upper bits 0.
- `resp_valid`, out, 1: high from capture completion until the next `arm` or `reset`.
- `resp_timeout`, out, 1: high from timeout until the next `arm` or `reset`.
- `busy`, out, 1: high in HUNT or SHIFT.

## Operation
- `sd_clk_in` and `sd_miso_in` each pass through a 2-flop synchronizer.
- The synced clock is registered once more for rising-edge detect. `strobe` = synced clock high AND previous low; it lasts exactly one cycle.
- On `strobe`, `bit_s` = the synced MISO value in that same cycle.
- Four states: IDLE, HUNT, SHIFT, DONE.
- IDLE:
  - waits for `arm`;
  - `arm` → HUNT; clear `resp_valid`, `resp_timeout`, `edge_cnt`, `bit_cnt`, `shreg`.
- HUNT, on `strobe`:
  - If `bit_s==0`: start bit. `shreg` ← 0, `bit_cnt` ← 1.
    - If `RESP_BITS==1`, complete immediately.
    - Otherwise → SHIFT.
  - Else: `edge_cnt` += 1. If `edge_cnt` reaches `TIMEOUT_EDGES` → DONE with `resp_timeout`=1 and `response_signal` = 16'hFFFF.
- SHIFT, on `strobe`:
  - `shreg` ← {`shreg`[14:0], `bit_s`}; `bit_cnt` += 1.
  - When `bit_cnt` reaches `RESP_BITS`, complete: `response_signal` ← final `shreg` masked to `RESP_BITS`, `resp_valid`=1, → DONE.
- DONE:
  - outputs hold;
  - `arm` → HUNT, same clearing as from IDLE.
- `arm` in HUNT or SHIFT: abort and restart HUNT, clearing counters and flags.
  - `response_signal` keeps its last value until a new completion or timeout.
- Simultaneous `arm` and `strobe`: `arm` wins; that strobe is discarded.
- `edge_cnt` is 16 bits and saturates; `bit_cnt` is 5 bits. Neither wraps.
- `strobe` in IDLE or DONE: ignored.

## Timing
- Reset values:
  - `response_signal` = 16'hFFFF;
  - `resp_valid` = 0, `resp_timeout` = 0, `busy` = 0;
  - state IDLE; synchronizer and edge flops 0.
- Reset applies mid-capture with no partial output.
- `strobe` asserts 3 `CLOCK_50` cycles after a `sd_clk_in` rising edge: 2 sync stages + 1 edge stage.
- MISO is sampled through an identical 2-flop path. It must be stable ≥3 cycles before and after the SD rising edge; at 250 kHz this is guaranteed (200 cycles per SD clock).
- `busy` rises the cycle after `arm`.
- Completion and timeout: `response_signal`, `resp_valid`/`resp_timeout` update, and `busy` falls, all on the cycle after the final `strobe`. These are registered outputs, stable together.
- Minimum capture time: `RESP_BITS` SD clocks after the start bit.
- Maximum capture time: (`TIMEOUT_EDGES` + `RESP_BITS`) SD clocks after `arm`.

## Test plan
- **R1 idle.** `arm`, 2 high bits, then 0000_0001 → `response_signal`=16'h0001 and `resp_valid`=1 one cycle after the 10th strobe; `resp_timeout`=0.
- **Late response.** `arm`, 40 high bits, then 0x00 → `response_signal`=16'h0000, `resp_valid`=1, no timeout.
- **No response.** `arm`, MISO held high for 64 SD edges → `resp_timeout`=1 and `response_signal`=16'hFFFF on the cycle after the 64th strobe; `resp_valid`=0; `busy`=0.
- **Re-arm mid-shift.** `arm`; card sends 0,0,0 then a second `arm`; then 0000_0101 → result 16'h0005; the first partial response is never reported.
- **Reset mid-shift.** `reset` during SHIFT → next cycle: all outputs at reset values, state IDLE; later strobes ignored until `arm`.
- **Arm/strobe collision.** `arm` in the same cycle as a strobe with MISO=0 → that bit is not counted as a start bit; the capture starts from the next strobe.
